alu_sched: RTL
==============

// Module: alu_sched
// PURPOSE
//  Shares the single combinational ALU between NUM_REQ requesters (e.g. decode issue, address-gen, debug port).
//  Round-robin arbitration, operand capture, one-cycle execute, registered result.
//  Result is held per requester until that requester accepts it. Sits between the issue stage and the ALU.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  REQ_W    $clog2(NUM_REQ)  grant index width (derived localparam, not overridable)
// PORTS
//  clk         in   1            single clock, rising edge
//  rst         in   1            asynchronous, active-high reset
//  req_valid   in   NUM_REQ      requester i presents an operation
//  req_ready   out  NUM_REQ      one-hot; operation of requester i accepted this cycle
//  req_op      in   NUM_REQ x 3  h2bp::alu_op_t per requester
//  req_a       in   NUM_REQ x 32 operand A per requester
//  req_b       in   NUM_REQ x 32 operand B per requester
//  rsp_valid   out  NUM_REQ      one-hot; result for requester i is available
//  rsp_ready   in   NUM_REQ      requester i consumes its result
//  rsp_result  out  32           result, shared bus, meaningful while any rsp_valid is high
//  busy        out  1            state != IDLE
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_result=0, busy=0, state=IDLE, rr pointer=0.
//  - Reset mid-operation drops the in-flight transaction; no response is issued.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant g = first valid index at or above ptr, wrapping.
//    req_ready[g]=1 combinationally in that cycle. op/a/b are latched at the edge; go to EXEC.
//    No valid: stay in IDLE, req_ready=0.
//  - EXEC: ALU evaluates the latched operands. Result is registered into rsp_result; go to RESP.
//  - RESP: rsp_valid[g]=1, and rsp_result stays stable. Leave for IDLE on the edge where rsp_ready[g]=1.
//    At that edge ptr=(g+1) mod NUM_REQ. rsp_ready of other requesters is ignored.
//  - Latency: accept in cycle N, rsp_valid high in N+2. Best throughput is 1 op per 3 cycles
//    (rsp_ready held high).
//  - req_ready is 0 in EXEC and RESP. A requester may drop req_valid before acceptance without penalty.
//  - ALU rules, 32-bit wrap:
//      ADD, SUB: modulo 2^32.
//      MULT: low 32 bits of the product.
//      AND, OR: bitwise.
//      LSHIFT, RSHIFT: logical, amount = full operand B; B>=32 gives 0.
//      Undefined encoding (3'd7) gives 0.
//  - Simultaneous valids: exactly one grant per IDLE cycle. Every continuously-valid requester
//    is served within NUM_REQ grants.
// CONFIGURATION
//  ALU_SCHED_FLAGS_EN defined: adds output rsp_flags (h2bp::flags_t {zero,negative,carry}), registered with rsp_result.
//    zero = result==0
//    negative = result[31]
//    carry = bit 32 of the 33-bit sum for ADD; borrow (a<b unsigned) for SUB; 0 for other ops.
//    Reset value 0.
//  Undefined: no rsp_flags port and no flag logic; all other behaviour identical.
// STRUCTURE
//  Package h2bp:
//    alu_op_t enum: opADD=0, opSUB=1, opMULT=2, opAND=3, opOR=4, opLSHIFT=5, opRSHIFT=6
//    flags_t packed struct
//    sched_state_t enum {IDLE, EXEC, RESP}
//  Sub-module rr_arbiter (NUM_REQ): req vector + ptr -> one-hot grant and index.
//  The existing h2bp ALU is instantiated as the datapath.
// TESTING
//  1. Reset, then req0 ADD a=5 b=7, rsp_ready0=1.
//     -> req_ready0 in cycle 0; rsp_valid0 in cycle 2 with rsp_result=12; busy back to 0 in cycle 3.
//  2. req0 and req1 valid in the same cycle, both SUB a=10 b=3, rsp_ready held high.
//     -> req0 granted first, then req1; both results are 7; grants alternate 0,1,0,1 while both stay valid.
//  3. req1 LSHIFT a=1 b=31 -> 0x80000000. Then b=32 -> 0. Then RSHIFT a=0x80000000 b=4 -> 0x08000000.
//  4. MULT a=0x10000 b=0x10000 -> 0. With rsp_ready0 low for 5 cycles:
//     -> rsp_valid0 and rsp_result held stable; req_ready stays 0 until rsp_ready0=1.
//  5. Assert rst while in EXEC -> all outputs 0 next cycle, no rsp_valid. Next request gets grant from ptr 0.
//  6. ALU_SCHED_FLAGS_EN:
//     ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1.
//     SUB 3-5 -> 0xFFFFFFFE, negative=1, carry=1.
//     op=7 -> 0, zero=1.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// ---------------------------------------------------------------------------
// Package h2bp
//  Shared types and ALU evaluation helpers for the alu_sched block.
//  - alu_op_t      : 3-bit operation encoding (3'd7 is undefined, evaluates to 0)
//  - flags_t       : {zero, negative, carry} result flags
//  - sched_state_t : scheduler FSM states
//  - alu_eval()    : the shared combinational ALU datapath
//  - alu_carry()   : carry/borrow flag for ADD/SUB, 0 for everything else
// ---------------------------------------------------------------------------
package h2bp;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    opADD    = 3'd0,
    opSUB    = 3'd1,
    opMULT   = 3'd2,
    opAND    = 3'd3,
    opOR     = 3'd4,
    opLSHIFT = 3'd5,
    opRSHIFT = 3'd6
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Combinational ALU. Shifts use the whole of operand B as the amount, so
  // any amount of 32 or more clears the result instead of wrapping modulo 32.
  function automatic logic [DATA_W-1:0] alu_eval(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      opADD:    res = a + b;
      opSUB:    res = a - b;
      opMULT:   res = a * b;
      opAND:    res = a & b;
      opOR:     res = a | b;
      opLSHIFT: res = (b >= 32'd32) ? '0 : (a << b[4:0]);
      opRSHIFT: res = (b >= 32'd32) ? '0 : (a >> b[4:0]);
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Carry-out of the 33-bit sum for ADD, unsigned borrow for SUB.
  function automatic logic alu_carry(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0] sum;
    logic            c;
    sum = {1'b0, a} + {1'b0, b};
    c   = 1'b0;
    case (op)
      opADD:   c = sum[DATA_W];
      opSUB:   c = (a < b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//  Round-robin pick: the first asserted request at or above ptr, wrapping
//  back to index 0. Purely combinational; the caller owns the pointer.
// Ports
//  req    in   NUM_REQ  request vector
//  ptr    in   REQ_W    highest-priority index this cycle
//  grant  out  NUM_REQ  one-hot grant (all zero when no request)
//  idx    out  REQ_W    index of the granted request (0 when none)
//  any    out  1        at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int k;
    // NOTE: every output of this block gets a default before any branch,
    // so no path can leave one unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    // Walk the requesters starting at ptr; the first hit wins and later
    // iterations are masked by 'any'.
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = REQ_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched
//  Shares one combinational ALU between NUM_REQ requesters. A round-robin
//  arbiter picks one requester in IDLE, its operands are captured, the ALU
//  result is registered in EXEC, and the result is held in RESP until the
//  granted requester accepts it.
//
//  Optional feature macro: ALU_SCHED_FLAGS_EN adds the rsp_flags output,
//  registered together with rsp_result.
//
// Ports
//  clk         in   1             rising-edge clock
//  rst         in   1             asynchronous, active-high reset
//  req_valid   in   NUM_REQ       requester i presents an operation
//  req_ready   out  NUM_REQ       one-hot, requester i accepted this cycle
//  req_op      in   NUM_REQ x 3   h2bp::alu_op_t encoding per requester
//  req_a       in   NUM_REQ x 32  operand A per requester
//  req_b       in   NUM_REQ x 32  operand B per requester
//  rsp_valid   out  NUM_REQ       one-hot, result for requester i available
//  rsp_ready   in   NUM_REQ       requester i consumes its result
//  rsp_result  out  32            shared result bus
//  busy        out  1             scheduler is not IDLE
//  rsp_flags   out  flags_t       {zero,negative,carry} (ALU_SCHED_FLAGS_EN only)
// ---------------------------------------------------------------------------
module alu_sched
  import h2bp::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][2:0]  req_op,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     busy
`ifdef ALU_SCHED_FLAGS_EN
  ,
  output flags_t                   rsp_flags
`endif
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state;
  logic [REQ_W-1:0]   ptr;
  logic [REQ_W-1:0]   gnt_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [REQ_W-1:0]   arb_idx;
  logic               arb_any;
  logic               accept;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        alu_res;
  logic [REQ_W-1:0]   ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // The grant is offered combinationally in IDLE so the requester sees its
  // acceptance in the same cycle. Held low while reset is asserted so the
  // outputs read all-zero during reset.
  assign accept    = (state == IDLE) && arb_any && !rst;
  assign req_ready = accept ? arb_grant : '0;
  assign busy      = (state != IDLE);

  // Pointer moves to the requester after the one just served.
  assign ptr_next = (gnt_q == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  assign alu_res = alu_eval(op_q, a_q, b_q);

  // NOTE: operand capture flops have no reset: they are only consumed in
  // EXEC, which is always preceded by a capture, so resetting them buys
  // nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req_op[arb_idx];
      a_q  <= req_a[arb_idx];
      b_q  <= req_b[arb_idx];
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values and updates together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_q      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
`ifdef ALU_SCHED_FLAGS_EN
      rsp_flags  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_q <= arb_idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_res;
          rsp_valid  <= NUM_REQ'(1) << gnt_q;
`ifdef ALU_SCHED_FLAGS_EN
          rsp_flags  <= '{zero:     (alu_res == '0),
                          negative: alu_res[31],
                          carry:    alu_carry(op_q, a_q, b_q)};
`endif
          state      <= RESP;
        end
        RESP: begin
          // Only the granted requester's rsp_ready can release the result.
          if (rsp_ready[gnt_q]) begin
            rsp_valid <= '0;
            ptr       <= ptr_next;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
